// File: rtl/gpio_cfg_pkg.sv
// Shared constants for the per-pad GPIO configuration shadow: word width,
// field bit positions, the reset default word and the FSM state encoding.
package gpio_cfg_pkg;

    localparam int GPIO_CFG_WIDTH = 13;

    localparam int MGMT_ENA    = 0;
    localparam int OUTENB      = 1;
    localparam int HOLDOVER    = 2;
    localparam int INP_DIS     = 3;
    localparam int IB_MODE_SEL = 4;
    localparam int ANA_EN      = 5;
    localparam int ANA_SEL     = 6;
    localparam int ANA_POL     = 7;
    localparam int SLOW        = 8;
    localparam int VTRIP       = 9;
    localparam int DM_LSB      = 10;
    localparam int DM_MSB      = 12;

    localparam logic [GPIO_CFG_WIDTH-1:0] GPIO_CFG_DEFAULT = 13'h0402;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/gpio_cfg_shift_chain.sv
// Serial shift register for one link of the GPIO config daisy chain.
// Bits enter at the LSB; the MSB is the chain output to the next pad.
// bit_cnt counts shifts since the last clear and saturates at WIDTH so an
// over-shifted word (upstream data passing through) still commits.
module gpio_cfg_shift_chain
    import gpio_cfg_pkg::*;
#(
    parameter int WIDTH = GPIO_CFG_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             data_in,
    input  logic             cnt_clr,
    input  logic             reg_clr,
    output logic [WIDTH-1:0] shift_reg,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             data_out
);

    // Shift register: cleared on reset/reload, otherwise shifts on strobe.
    // A commit clears only the count, so chain contents persist.
    always_ff @(posedge clk) begin
        if (rst || reg_clr) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[WIDTH-2:0], data_in};
        end
    end

    // Shift counter, saturating at WIDTH.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            bit_cnt <= '0;
        end else if (shift_en && (bit_cnt != CNT_W'(WIDTH))) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign data_out = shift_reg[WIDTH-1];

endmodule

// File: rtl/gpio_config_shadow.sv
// Per-pad GPIO configuration shadow. Holds the live pad configuration,
// loaded from mask defaults on reset/reload or from the serial chain on a
// full-width commit. Short commits leave config alone and set a sticky error.
// Event priority: reset, reload_defaults, serial_load, serial_shift.
module gpio_config_shadow
    import gpio_cfg_pkg::*;
#(
    parameter int WIDTH = GPIO_CFG_WIDTH
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] gpio_defaults,
    input  logic             serial_shift,
    input  logic             serial_data_in,
    input  logic             serial_load,
    input  logic             reload_defaults,
    output logic             serial_data_out,
    output logic [WIDTH-1:0] config_out,
    output logic             mgmt_ena,
    output logic             outenb,
    output logic             holdover,
    output logic             inp_dis,
    output logic             ib_mode_sel,
    output logic             ana_en,
    output logic             ana_sel,
    output logic             ana_pol,
    output logic             slow_sel,
    output logic             vtrip_sel,
    output logic [2:0]       dm,
    output logic             load_done,
    output logic             load_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    cfg_state_e       state, state_nxt;
    logic [WIDTH-1:0] cfg, cfg_nxt;
    logic             done_nxt, err_nxt;
    logic             shift_en, cnt_clr, reg_clr;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;

    gpio_cfg_shift_chain #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_chain (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .shift_en  (shift_en),
        .data_in   (serial_data_in),
        .cnt_clr   (cnt_clr),
        .reg_clr   (reg_clr),
        .shift_reg (shift_reg),
        .bit_cnt   (bit_cnt),
        .data_out  (serial_data_out)
    );

    // State, config and flag registers; reset captures the defaults word.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cfg       <= gpio_defaults;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg       <= cfg_nxt;
            load_done <= done_nxt;
            load_err  <= err_nxt;
        end
    end

    // Next-state: a load is judged on the pre-shift count and drops any
    // simultaneous shift strobe.
    always_comb begin
        state_nxt = state;
        cfg_nxt   = cfg;
        done_nxt  = 1'b0;
        err_nxt   = load_err;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        reg_clr   = 1'b0;
        if (reload_defaults) begin
            cfg_nxt   = gpio_defaults;
            err_nxt   = 1'b0;
            cnt_clr   = 1'b1;
            reg_clr   = 1'b1;
            state_nxt = IDLE;
        end else if (serial_load) begin
            if (state == SHIFT && bit_cnt == CNT_W'(WIDTH)) begin
                cfg_nxt  = shift_reg;
                done_nxt = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
        end else if (serial_shift) begin
            shift_en  = 1'b1;
            state_nxt = SHIFT;
        end
    end

    assign config_out  = cfg;
    assign mgmt_ena    = cfg[MGMT_ENA];
    assign outenb      = cfg[OUTENB];
    assign holdover    = cfg[HOLDOVER];
    assign inp_dis     = cfg[INP_DIS];
    assign ib_mode_sel = cfg[IB_MODE_SEL];
    assign ana_en      = cfg[ANA_EN];
    assign ana_sel     = cfg[ANA_SEL];
    assign ana_pol     = cfg[ANA_POL];
    assign slow_sel    = cfg[SLOW];
    assign vtrip_sel   = cfg[VTRIP];
    assign dm          = cfg[DM_MSB:DM_LSB];

endmodule

// File: tb/tb_gpio_config_shadow.sv
// Randomized + directed bench for gpio_config_shadow against a behavioural
// model (integer shift word, saturating count, flags).
module tb_gpio_config_shadow;
    import gpio_cfg_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i, serial_shift, serial_data_in, serial_load, reload_defaults;
    logic [12:0] gpio_defaults = 13'h0402;
    logic        serial_data_out, mgmt_ena, outenb, holdover, inp_dis, ib_mode_sel;
    logic        ana_en, ana_sel, ana_pol, slow_sel, vtrip_sel, load_done, load_err;
    logic [12:0] config_out;
    logic [2:0]  dm;

    int errs = 0;
    int checks = 0;

    // behavioural model
    int unsigned m_sr, m_cnt, m_cfg;
    bit          m_err, m_done;

    gpio_config_shadow dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .gpio_defaults(gpio_defaults),
        .serial_shift(serial_shift), .serial_data_in(serial_data_in),
        .serial_load(serial_load), .reload_defaults(reload_defaults),
        .serial_data_out(serial_data_out), .config_out(config_out),
        .mgmt_ena(mgmt_ena), .outenb(outenb), .holdover(holdover), .inp_dis(inp_dis),
        .ib_mode_sel(ib_mode_sel), .ana_en(ana_en), .ana_sel(ana_sel), .ana_pol(ana_pol),
        .slow_sel(slow_sel), .vtrip_sel(vtrip_sel), .dm(dm),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic chk_all();
        logic [12:0] c;
        logic [11:0] f;
        c = 13'(m_cfg);
        f = {vtrip_sel, slow_sel, ana_pol, ana_sel, ana_en, ib_mode_sel,
             inp_dis, holdover, outenb, mgmt_ena, 2'b00};
        chk("config_out", 32'(config_out), 32'(c));
        chk("fields", 32'({dm, f[11:2]}), 32'(c));
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("sdo", 32'(serial_data_out), (m_sr >> 12) & 1);
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input bit rst, input bit rel, input bit ld, input bit sh, input bit din);
        wb_rst_i = rst; reload_defaults = rel; serial_load = ld;
        serial_shift = sh; serial_data_in = din;
        @(posedge wb_clk_i);
        m_done = 0;
        if (rst || rel) begin
            m_cfg = gpio_defaults; m_sr = 0; m_cnt = 0; m_err = 0;
        end else if (ld) begin
            if (m_cnt == 13) begin
                m_cfg = m_sr; m_done = 1;
            end else begin
                m_err = 1;
            end
            m_cnt = 0;
        end else if (sh) begin
            m_sr  = ((m_sr << 1) | din) & 32'h1FFF;
            m_cnt = (m_cnt < 13) ? m_cnt + 1 : 13;
        end
        #1;
        chk_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic shift_word(input int unsigned w, input int n);
        for (int i = n - 1; i >= 0; i--) step(0, 0, 0, 1, w[i]);
    endtask

    initial begin
        m_sr = 0; m_cnt = 0; m_cfg = 0; m_err = 0; m_done = 0;
        wb_rst_i = 1; reload_defaults = 0; serial_load = 0; serial_shift = 0; serial_data_in = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // reset state, explicit
        chk("rst_cfg", 32'(config_out), 32'h0402);
        chk("rst_dm", 32'(dm), 32'd1);
        chk("rst_outenb", 32'(outenb), 32'd1);
        chk("rst_mgmt", 32'(mgmt_ena), 32'd0);
        chk("rst_sdo", 32'(serial_data_out), 32'd0);
        idle();

        // full word commit
        shift_word(32'h1803, 13);
        step(0, 0, 1, 0, 0);
        chk("ld_cfg", 32'(config_out), 32'h1803);
        chk("ld_done", 32'(load_done), 32'd1);
        chk("ld_dm", 32'(dm), 32'd6);
        chk("ld_mgmt", 32'(mgmt_ena), 32'd1);
        idle();
        chk("ld_done_gone", 32'(load_done), 32'd0);

        // daisy-chain pass-through
        shift_word(32'h0AAA, 13);
        for (int i = 12; i >= 0; i--) begin
            chk("chain_sdo", 32'(serial_data_out), (32'h0AAA >> i) & 1);
            step(0, 0, 0, 1, 1'((32'h1555 >> i) & 1));
        end
        step(0, 0, 1, 0, 0);
        chk("chain_cfg", 32'(config_out), 32'h1555);

        // short load then reload
        step(0, 1, 0, 0, 0);
        shift_word(32'h7F, 7);
        step(0, 0, 1, 0, 0);
        chk("short_cfg", 32'(config_out), 32'h0402);
        chk("short_err", 32'(load_err), 32'd1);
        chk("short_nodone", 32'(load_done), 32'd0);
        idle(); idle();
        chk("err_sticky", 32'(load_err), 32'd1);
        step(0, 1, 0, 0, 0);
        chk("reload_err", 32'(load_err), 32'd0);
        chk("reload_cfg", 32'(config_out), 32'h0402);

        // 12 shifts, then shift+load together: load judged pre-shift
        shift_word(32'hFFF, 12);
        step(0, 0, 1, 1, 1);
        chk("sl_err", 32'(load_err), 32'd1);
        chk("sl_cfg", 32'(config_out), 32'h0402);
        step(0, 1, 0, 0, 0);

        // reset mid-sequence, finish remaining bits, load is short
        shift_word(32'h1803 >> 6, 7);
        step(1, 0, 0, 0, 0);
        chk("mid_rst_cfg", 32'(config_out), 32'h0402);
        shift_word(32'h1803, 6);
        step(0, 0, 1, 0, 0);
        chk("mid_rst_err", 32'(load_err), 32'd1);
        chk("mid_rst_cfg2", 32'(config_out), 32'h0402);

        // randomized phase
        for (int n = 0; n < 300; n++) begin
            int unsigned k;
            k = $urandom_range(0, 9);
            if (k < 6) begin
                // mostly full or over-length words, then a load
                shift_word($urandom, (k < 4) ? 13 : int'($urandom_range(1, 30)));
                step(0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1));
            end else begin
                for (int j = 0; j < 8; j++) begin
                    int unsigned r;
                    r = $urandom_range(0, 99);
                    step(r < 2, r >= 2 && r < 5, r >= 5 && r < 15, r >= 10, $urandom_range(0, 1));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
